// File: rtl/uart_rx.sv
// UART receive deframer: 16x-oversampled rxd, LSB-first 8-bit data, 1 or 2 stop bits.
// Optional parity stage is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       rx_tick,
    input  logic       rx_enable,
    input  logic       nstop,
    input  logic       rxd,
`ifdef UART_RX_PARITY_EN
    input  logic       parity_en,
    input  logic       parity_odd,
    output logic       parity_error,
`endif
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
    } state_t;

    state_t                 state, state_nxt;
    logic [TW-1:0]          tick_cnt, tick_nxt;
    logic [2:0]             bit_cnt, bit_nxt;
    logic [7:0]             shift_q, shift_nxt;
    logic [7:0]             data_nxt;
    logic                   nstop_q, nstop_nxt;
    logic                   valid_nxt, ferr_nxt, busy_nxt;
    logic                   commit_ok;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd_s;

    // Metastability synchronizer; flops reset to the idle (mark) level.
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) sync_q <= '1;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
    assign rxd_s = sync_q[SYNC_STAGES-1];

`ifdef UART_RX_PARITY_EN
    logic pbad_q, pbad_nxt, perr_nxt;
    assign commit_ok = ~pbad_q;
`else
    assign commit_ok = 1'b1;
`endif

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift_q;
        data_nxt  = rx_data;
        nstop_nxt = nstop_q;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_nxt  = pbad_q;
        perr_nxt  = 1'b0;
`endif
        if (!rx_enable) begin
            state_nxt = S_IDLE;
            tick_nxt  = '0;
            bit_nxt   = '0;
        end else if (rx_tick) begin
            case (state)
                S_IDLE: begin
                    if (!rxd_s) begin
                        state_nxt = S_START;
                        tick_nxt  = '0;
`ifdef UART_RX_PARITY_EN
                        pbad_nxt  = 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (tick_cnt == HALF_M1) begin
                        tick_nxt  = '0;
                        bit_nxt   = '0;
                        state_nxt = rxd_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_nxt = tick_cnt + TW'(1);
                    end
                end
                S_DATA: begin
                    tick_nxt = tick_cnt + TW'(1);
                    if (tick_cnt == FULL_M1) begin
                        shift_nxt = {rxd_s, shift_q[7:1]};
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            if (parity_en) begin
                                state_nxt = S_PARITY;
                            end else begin
                                state_nxt = S_STOP1;
                                nstop_nxt = nstop;
                            end
`else
                            state_nxt = S_STOP1;
                            nstop_nxt = nstop;
`endif
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    tick_nxt = tick_cnt + TW'(1);
                    if (tick_cnt == FULL_M1) begin
                        // Expected bit makes total ones even (or odd when parity_odd).
                        if (rxd_s != ((^shift_q) ^ parity_odd)) begin
                            perr_nxt = 1'b1;
                            pbad_nxt = 1'b1;
                        end
                        state_nxt = S_STOP1;
                        nstop_nxt = nstop;
                    end
                end
`endif
                S_STOP1: begin
                    tick_nxt = tick_cnt + TW'(1);
                    if (tick_cnt == FULL_M1) begin
                        if (!rxd_s) begin
                            ferr_nxt  = 1'b1;
                            state_nxt = S_IDLE;
                        end else if (nstop_q) begin
                            state_nxt = S_STOP2;
                        end else begin
                            state_nxt = S_IDLE;
                            data_nxt  = commit_ok ? shift_q : rx_data;
                            valid_nxt = commit_ok;
                        end
                    end
                end
                S_STOP2: begin
                    tick_nxt = tick_cnt + TW'(1);
                    if (tick_cnt == FULL_M1) begin
                        state_nxt = S_IDLE;
                        if (!rxd_s) begin
                            ferr_nxt = 1'b1;
                        end else begin
                            data_nxt  = commit_ok ? shift_q : rx_data;
                            valid_nxt = commit_ok;
                        end
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state         <= S_IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_q       <= '0;
            nstop_q       <= 1'b0;
            rx_data       <= 8'h00;
            rx_data_valid <= 1'b0;
            frame_error   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            tick_cnt      <= tick_nxt;
            bit_cnt       <= bit_nxt;
            shift_q       <= shift_nxt;
            nstop_q       <= nstop_nxt;
            rx_data       <= data_nxt;
            rx_data_valid <= valid_nxt;
            frame_error   <= ferr_nxt;
            busy          <= busy_nxt;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            pbad_q       <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            pbad_q       <= pbad_nxt;
            parity_error <= perr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus hand sequences for timing,
// glitch rejection, back-to-back two-stop frames, enable abort and mid-frame reset.
module tb_uart_rx;

    logic       CLK_I;
    logic       RST_I;
    logic       rx_tick;
    logic       rx_enable;
    logic       nstop;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       frame_error;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_en  = 1'b0;
    logic       parity_odd = 1'b0;
    logic       parity_error;
`endif

    uart_rx dut (
        .CLK_I         (CLK_I),
        .RST_I         (RST_I),
        .rx_tick       (rx_tick),
        .rx_enable     (rx_enable),
        .nstop         (nstop),
        .rxd           (rxd),
`ifdef UART_RX_PARITY_EN
        .parity_en     (parity_en),
        .parity_odd    (parity_odd),
        .parity_error  (parity_error),
`endif
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .frame_error   (frame_error),
        .busy          (busy)
    );

    initial begin
        CLK_I = 1'b0;
        forever #5 CLK_I = ~CLK_I;
    end

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;

    always @(negedge CLK_I) begin
        if (rx_data_valid) valid_cnt++;
        if (frame_error)   ferr_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One rx_tick pulse followed by an idle cycle (tick every 3 clocks).
    task automatic do_tick();
        @(negedge CLK_I) rx_tick = 1'b1;
        @(negedge CLK_I) rx_tick = 1'b0;
        @(negedge CLK_I);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (16) do_tick();
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) do_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic two, input logic s1, input logic s2);
        nstop = two;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(s1);
        if (two) send_bit(s2);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       two;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        int         exp_valid;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];
    int   v0, f0;

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hFF, 0, 1};
        vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b1, 8'h81, 1, 0};
        vecs[5] = '{8'h7E, 1'b1, 1'b1, 1'b0, 8'h81, 0, 1};

        RST_I = 1'b0; rx_tick = 1'b0; rx_enable = 1'b1; nstop = 1'b0; rxd = 1'b1;

        // Reset held while rxd toggles with ticks present.
        repeat (20) begin
            @(negedge CLK_I);
            rxd     = ~rxd;
            rx_tick = ~rx_tick;
        end
        @(negedge CLK_I);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_valid", 32'(rx_data_valid), 32'h0);
        chk("reset_ferr", 32'(frame_error), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        rxd = 1'b1; rx_tick = 1'b0;
        @(negedge CLK_I) RST_I = 1'b1;
        idle(4);

        // 8'hA5 with exact commit timing around the stop-bit mid sample.
        nstop = 1'b0;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(vecs[0].data[i]);
        rxd = 1'b1;
        repeat (9) do_tick();
        chk("a5_valid_early", 32'(rx_data_valid), 32'h0);
        chk("a5_busy_stop", 32'(busy), 32'h1);
        @(negedge CLK_I) rx_tick = 1'b1;
        @(negedge CLK_I) rx_tick = 1'b0;
        chk("a5_valid_pulse", 32'(rx_data_valid), 32'h1);
        chk("a5_data", 32'(rx_data), 32'hA5);
        chk("a5_ferr", 32'(frame_error), 32'h0);
        chk("a5_busy_after", 32'(busy), 32'h0);
        @(negedge CLK_I);
        chk("a5_valid_one_cycle", 32'(rx_data_valid), 32'h0);
        repeat (6) do_tick();
        idle(4);

        // Frame table.
        for (int k = 0; k < 6; k++) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[k].data, vecs[k].two, vecs[k].s1, vecs[k].s2);
            idle(20);
            chk($sformatf("vec%0d_valid_cnt", k), 32'(valid_cnt - v0), 32'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_ferr_cnt", k), 32'(ferr_cnt - f0), 32'(vecs[k].exp_ferr));
            chk($sformatf("vec%0d_rx_data", k), 32'(rx_data), 32'(vecs[k].exp_data));
            chk($sformatf("vec%0d_busy", k), 32'(busy), 32'h0);
        end

        // Back-to-back 8'h00 then 8'hFF with two stop bits.
        v0 = valid_cnt;
        nstop = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b0);
        send_bit(1'b1);
        rxd = 1'b1;
        repeat (5) do_tick();
        chk("b2b_busy_stop2_a", 32'(busy), 32'h1);
        repeat (11) do_tick();
        chk("b2b_data_a", 32'(rx_data), 32'h00);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        send_bit(1'b1);
        rxd = 1'b1;
        repeat (5) do_tick();
        chk("b2b_busy_stop2_b", 32'(busy), 32'h1);
        repeat (11) do_tick();
        idle(4);
        chk("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
        chk("b2b_data_b", 32'(rx_data), 32'hFF);

        // Start glitch: rxd low for 4 ticks only.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        nstop = 1'b0;
        rxd = 1'b0;
        repeat (4) do_tick();
        chk("glitch_busy_start", 32'(busy), 32'h1);
        idle(16);
        chk("glitch_busy_idle", 32'(busy), 32'h0);
        chk("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // rx_enable dropped after data bit 3 of 8'h55.
        v0 = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(vecs[0].data[i] ^ 1'b0 ? 1'b1 : 1'b0);
        @(negedge CLK_I) rx_enable = 1'b0;
        @(negedge CLK_I);
        chk("abort_busy", 32'(busy), 32'h0);
        for (int i = 4; i < 8; i++) send_bit(1'b0);
        idle(20);
        chk("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        chk("abort_rx_data_kept", 32'(rx_data), 32'hFF);
        rx_enable = 1'b1;
        idle(4);
        send_frame(8'h55, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("reenable_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("reenable_data", 32'(rx_data), 32'h55);

        // Reset asserted mid-frame.
        v0 = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        @(negedge CLK_I) RST_I = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_rx_data", 32'(rx_data), 32'h00);
        rxd = 1'b1;
        @(negedge CLK_I) RST_I = 1'b1;
        idle(4);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        idle(20);
        chk("midrst_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        chk("midrst_next_data", 32'(rx_data), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
